// File: rtl/avalon_slave_mem_pkg.sv
// Shared types and widths for the Avalon-MM slave memory.
package avalon_slave_mem_pkg;

    localparam int unsigned AVALON_DATA_W = 32;
    localparam int unsigned AVALON_BE_W   = AVALON_DATA_W / 8;

    typedef struct packed {
        logic                     valid;
        logic                     is_read;
        logic [AVALON_DATA_W-1:0] data;
    } avalon_resp_entry_t;

endpackage

// File: rtl/avalon_slave_mem_if.sv
// Avalon-MM bus bundle between the core master and the slave memory.
interface avalon_slave_mem_if;
    import avalon_slave_mem_pkg::*;

    logic [31:0]              addr;
    logic                     read;
    logic                     write;
    logic [AVALON_BE_W-1:0]   byteenable;
    logic [AVALON_DATA_W-1:0] writedata;
    logic                     waitrequest;
    logic [AVALON_DATA_W-1:0] readdata;
    logic                     readdatavalid;
    logic                     writeresponsevalid;

    modport master (
        output addr, read, write, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid, writeresponsevalid
    );

    modport slave (
        input  addr, read, write, byteenable, writedata,
        output waitrequest, readdata, readdatavalid, writeresponsevalid
    );

endinterface

// File: rtl/avalon_slave_resp_pipe.sv
// Fixed-latency response shift register; a synchronous clear drops all in-flight entries.
module avalon_slave_resp_pipe
    import avalon_slave_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  avalon_resp_entry_t entry_i,
    output avalon_resp_entry_t entry_o
);

    avalon_resp_entry_t stage_q [DEPTH];
    avalon_resp_entry_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = entry_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '{default: '0};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign entry_o = stage_q[DEPTH-1];

endmodule

// File: rtl/avalon_slave_mem.sv
// Avalon-MM slave memory with wait states, an outstanding-command limit and
// in-order fixed-latency read data / write acknowledgements.
module avalon_slave_mem
    import avalon_slave_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned WAIT_CYCLES  = 0,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_PENDING  = 2
) (
    input  logic               clk,
    input  logic               rst,
    avalon_slave_mem_if.slave  bus
);

    localparam int unsigned AW  = $clog2(DEPTH_WORDS);
    localparam int unsigned WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned PCW = $clog2(MAX_PENDING + 1);

    logic [AVALON_DATA_W-1:0] mem [DEPTH_WORDS];

    logic [WCW-1:0]           wait_cnt_q, wait_cnt_d;
    logic [PCW-1:0]           pending_q, pending_d;
    logic [AVALON_DATA_W-1:0] readdata_q, readdata_d;

    logic               req, accept, wr_en, resp_valid, rd_valid, wr_valid;
    logic [AW-1:0]      widx;
    avalon_resp_entry_t pipe_in, pipe_out;
    logic               unused_addr;

    assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};

    always_comb begin
        req        = bus.read | bus.write;
        widx       = bus.addr[2 +: AW];
        resp_valid = pipe_out.valid;
        // A response leaving this cycle frees a slot, so a full slave can still accept.
        accept     = ~rst & req & (wait_cnt_q == WCW'(WAIT_CYCLES))
                   & ((pending_q < PCW'(MAX_PENDING)) | resp_valid);
        wr_en      = accept & ~bus.read & bus.write;

        wait_cnt_d = wait_cnt_q;
        if (!req || accept) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WCW'(WAIT_CYCLES)) begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
        end

        pending_d = pending_q;
        if (accept && !resp_valid) begin
            pending_d = pending_q + PCW'(1);
        end else if (!accept && resp_valid) begin
            pending_d = pending_q - PCW'(1);
        end

        pipe_in.valid   = accept;
        pipe_in.is_read = bus.read;
        pipe_in.data    = bus.read ? mem[widx] : '0;

        rd_valid   = ~rst & pipe_out.valid & pipe_out.is_read;
        wr_valid   = ~rst & pipe_out.valid & ~pipe_out.is_read;
        readdata_d = rd_valid ? pipe_out.data : readdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            pending_q  <= '0;
            readdata_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            pending_q  <= pending_d;
            readdata_q <= readdata_d;
        end
    end

    // Memory contents survive reset; only accepted writes touch them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < AVALON_BE_W; i++) begin
                if (bus.byteenable[i]) begin
                    mem[widx][8*i +: 8] <= bus.writedata[8*i +: 8];
                end
            end
        end
    end

    avalon_slave_resp_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_resp_pipe (
        .clk     (clk),
        .rst     (rst),
        .entry_i (pipe_in),
        .entry_o (pipe_out)
    );

    assign bus.waitrequest        = ~accept;
    assign bus.readdatavalid      = rd_valid;
    assign bus.writeresponsevalid = wr_valid;
    assign bus.readdata           = readdata_d;

endmodule

// File: tb/tb_avalon_slave_mem.sv
// Scoreboard bench for avalon_slave_mem across three parameter sets.
module tb_avalon_slave_mem;

    localparam int NDUT = 3;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int lat [NDUT] = '{2, 2, 3};

    logic        rst_v [NDUT];
    logic        rd_v  [NDUT];
    logic        wr_v  [NDUT];
    logic [31:0] ad_v  [NDUT];
    logic [31:0] wd_v  [NDUT];
    logic [3:0]  be_v  [NDUT];
    logic        wreq  [NDUT];
    logic        rdv   [NDUT];
    logic        wrv   [NDUT];
    logic [31:0] rdat  [NDUT];

    exp_t exp_q [NDUT][$];

    avalon_slave_mem_if bus0 ();
    avalon_slave_mem_if bus1 ();
    avalon_slave_mem_if bus2 ();

    assign bus0.addr = ad_v[0]; assign bus0.read = rd_v[0]; assign bus0.write = wr_v[0];
    assign bus0.byteenable = be_v[0]; assign bus0.writedata = wd_v[0];
    assign bus1.addr = ad_v[1]; assign bus1.read = rd_v[1]; assign bus1.write = wr_v[1];
    assign bus1.byteenable = be_v[1]; assign bus1.writedata = wd_v[1];
    assign bus2.addr = ad_v[2]; assign bus2.read = rd_v[2]; assign bus2.write = wr_v[2];
    assign bus2.byteenable = be_v[2]; assign bus2.writedata = wd_v[2];

    assign wreq[0] = bus0.waitrequest; assign rdv[0] = bus0.readdatavalid;
    assign wrv[0] = bus0.writeresponsevalid; assign rdat[0] = bus0.readdata;
    assign wreq[1] = bus1.waitrequest; assign rdv[1] = bus1.readdatavalid;
    assign wrv[1] = bus1.writeresponsevalid; assign rdat[1] = bus1.readdata;
    assign wreq[2] = bus2.waitrequest; assign rdv[2] = bus2.readdatavalid;
    assign wrv[2] = bus2.writeresponsevalid; assign rdat[2] = bus2.readdata;

    avalon_slave_mem #(
        .DEPTH_WORDS (1024), .WAIT_CYCLES (0), .READ_LATENCY (2), .MAX_PENDING (2)
    ) dut0 (.clk (clk), .rst (rst_v[0]), .bus (bus0));

    avalon_slave_mem #(
        .DEPTH_WORDS (1024), .WAIT_CYCLES (3), .READ_LATENCY (2), .MAX_PENDING (2)
    ) dut1 (.clk (clk), .rst (rst_v[1]), .bus (bus1));

    avalon_slave_mem #(
        .DEPTH_WORDS (1024), .WAIT_CYCLES (0), .READ_LATENCY (3), .MAX_PENDING (1)
    ) dut2 (.clk (clk), .rst (rst_v[2]), .bus (bus2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    // Response monitor: every response must match the head of its DUT's queue.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < NDUT; i++) begin
            if (rdv[i] || wrv[i]) begin
                if (exp_q[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut%0d_unexpected_resp: rdv=%b wrv=%b, expected no response (cycle %0d)",
                             i, rdv[i], wrv[i], cyc);
                end else begin
                    e = exp_q[i].pop_front();
                    check($sformatf("dut%0d_resp_kind", i), {30'b0, rdv[i], wrv[i]},
                          {30'b0, e.is_read, !e.is_read});
                    check($sformatf("dut%0d_resp_cycle", i), cyc, e.due);
                    if (e.is_read) check($sformatf("dut%0d_readdata", i), rdat[i], e.data);
                end
            end else if (exp_q[i].size() != 0 && exp_q[i][0].due < cyc) begin
                e = exp_q[i].pop_front();
                checks++;
                errors++;
                $display("FAIL dut%0d_missing_resp: no response, expected one at cycle %0d", i, e.due);
            end
        end
    end

    // Presents one command from just after a posedge; returns just after the posedge ending its accept cycle.
    task automatic issue(input int s, input bit r, input bit w, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] d,
                         input int exp_wait, input logic [31:0] exp_rd);
        int   waits = 0;
        bit   done  = 0;
        exp_t e;
        rd_v[s] = r; wr_v[s] = w; ad_v[s] = a; be_v[s] = be; wd_v[s] = d;
        while (!done) begin
            @(negedge clk);
            if (!wreq[s]) begin
                done = 1;
                e.is_read = r;
                e.data    = exp_rd;
                e.due     = cyc + lat[s];
                exp_q[s].push_back(e);
            end else begin
                waits++;
                if (waits > 40) begin
                    checks++;
                    errors++;
                    $display("FAIL dut%0d_accept_timeout: no accept after %0d cycles, expected %0d waits",
                             s, waits, exp_wait);
                    done = 1;
                end
            end
        end
        check($sformatf("dut%0d_wait_cycles addr=0x%0h", s, a), waits, exp_wait);
        @(posedge clk); #1;
        rd_v[s] = 1'b0; wr_v[s] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            rst_v[i] = 1'b1; rd_v[i] = 1'b0; wr_v[i] = 1'b0;
            ad_v[i] = '0; wd_v[i] = '0; be_v[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("dut%0d_rst_waitrequest", i), {31'b0, wreq[i]}, 32'd1);
            check($sformatf("dut%0d_rst_readdatavalid", i), {31'b0, rdv[i]}, 32'd0);
            check($sformatf("dut%0d_rst_writeresp", i), {31'b0, wrv[i]}, 32'd0);
            check($sformatf("dut%0d_rst_readdata", i), rdat[i], 32'd0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < NDUT; i++) rst_v[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++)
            check($sformatf("dut%0d_idle_waitrequest", i), {31'b0, wreq[i]}, 32'd1);
        @(posedge clk); #1;

        // Byte-lane writes, preload, back-to-back reads.
        issue(0, 0, 1, 32'h10, 4'b1111, 32'h1122_3344, 0, 32'h0);
        issue(0, 0, 1, 32'h10, 4'b0101, 32'hAABB_CCDD, 0, 32'h0);
        for (int i = 0; i < 4; i++) issue(0, 0, 1, 32'(4 * i), 4'b1111, 32'(i), 0, 32'h0);
        for (int i = 0; i < 4; i++) issue(0, 1, 0, 32'(4 * i), 4'b0000, 32'h0, 0, 32'(i));
        issue(0, 1, 0, 32'h10, 4'b0000, 32'h0, 0, 32'h11BB_33DD);

        // Read wins over write; memory must be unchanged.
        issue(0, 1, 1, 32'h8, 4'b1111, 32'hDEAD_BEEF, 0, 32'h2);
        issue(0, 1, 0, 32'h8, 4'b0000, 32'h0, 0, 32'h2);

        // readdata holds across idle cycles and write responses.
        idle(4);
        @(negedge clk); check("dut0_readdata_hold_idle", rdat[0], 32'h2);
        @(posedge clk); #1;
        issue(0, 0, 1, 32'h20, 4'b1111, 32'h55, 0, 32'h0);
        idle(4);
        @(negedge clk); check("dut0_readdata_hold_write", rdat[0], 32'h2);
        @(posedge clk); #1;

        // Reset the cycle after a read accept: response dropped, memory kept.
        issue(0, 1, 0, 32'hC, 4'b0000, 32'h0, 0, 32'h3);
        rst_v[0] = 1'b1;
        exp_q[0].delete();
        rd_v[0] = 1'b1; ad_v[0] = 32'h0;
        @(negedge clk); check("dut0_midrst_waitrequest", {31'b0, wreq[0]}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("dut0_midrst_waitrequest2", {31'b0, wreq[0]}, 32'd1);
        check("dut0_midrst_readdata", rdat[0], 32'h0);
        @(posedge clk); #1;
        rst_v[0] = 1'b0; rd_v[0] = 1'b0;
        idle(6);
        issue(0, 1, 0, 32'hC, 4'b0000, 32'h0, 0, 32'h3);
        issue(0, 1, 0, 32'h10, 4'b0000, 32'h0, 0, 32'h11BB_33DD);

        // Wait states, including a dropped request restarting the count.
        issue(1, 0, 1, 32'h0, 4'b1111, 32'hCAFE_F00D, 3, 32'h0);
        issue(1, 1, 0, 32'h0, 4'b0000, 32'h0, 3, 32'hCAFE_F00D);
        rd_v[1] = 1'b1; ad_v[1] = 32'h0;
        idle(2);
        rd_v[1] = 1'b0;
        idle(1);
        issue(1, 1, 0, 32'h0, 4'b0000, 32'h0, 3, 32'hCAFE_F00D);

        // Pending limit of one with latency three: an accept every third cycle.
        for (int i = 0; i < 4; i++)
            issue(2, 0, 1, 32'(4 * i), 4'b1111, 32'h100 + 32'(i), (i == 0) ? 0 : 2, 32'h0);
        for (int i = 0; i < 4; i++)
            issue(2, 1, 0, 32'(4 * i), 4'b0000, 32'h0, 2, 32'h100 + 32'(i));

        begin
            int budget = 0;
            while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && budget < 30) begin
                @(posedge clk);
                budget++;
            end
        end
        idle(3);
        for (int i = 0; i < NDUT; i++)
            check($sformatf("dut%0d_queue_drained", i), exp_q[i].size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
